lcd_pixel_fx: RTL and testbench

Parametrised LCD post-processing pipeline between the console core's pixel output and the video mixer. It converts BPP-bit LCD shade indices to 24-bit RGB through a writable palette. It optionally blends each pixel with the same pixel of the previous frame to emulate LCD ghosting. It darkens background pixels that sit below and to the right of non-background pixels to emulate drop shadows. Frame size and shade depth are parameters, so the block serves any monochrome-LCD handheld core, not only 160x150, 2-bit panels.

---
 rtl/lcd_pixel_fx.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_pixel_fx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_fx.sv
// lcd_pixel_fx: LCD post-processing between a handheld core's pixel output and
// the video mixer. Shade index -> writable palette -> optional blend with the
// previous frame (LCD ghosting) -> optional drop shadow -> registered RGB.
// Two ce_pix stages: stage 1 does RAM reads and registers cur/src, stage 2
// does palette, blend and shadow and registers the colour.
//
// Build option: define LCD_FX_SHADOW_EN to build the line buffer and shadow
// logic; without it shadow_en is ignored and output is the blended colour.
//
// Ports:
//   clk, reset            pixel clock, async active-high reset
//   ce_pix                pixel clock enable; all pipeline state moves on it
//   pixel                 BPP-bit shade index, 0 = background
//   hsync/vsync/hblank/vblank   core timing, sampled on ce_pix
//   blend_en, shadow_en   quasi-static effect enables
//   pal_wr/pal_addr/pal_din     palette write port (not gated by ce_pix)
//   r, g, b               output colour
//   *_o                   timing delayed to match r/g/b
module lcd_pixel_fx #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 150,
  parameter int unsigned BPP    = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce_pix,
  input  logic [BPP-1:0] pixel,
  input  logic           hsync,
  input  logic           vsync,
  input  logic           hblank,
  input  logic           vblank,
  input  logic           blend_en,
  input  logic           shadow_en,
  input  logic           pal_wr,
  input  logic [BPP-1:0] pal_addr,
  input  logic [23:0]    pal_din,
  output logic [7:0]     r,
  output logic [7:0]     g,
  output logic [7:0]     b,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           hblank_o,
  output logic           vblank_o
);

  localparam int unsigned NPAL  = 1 << BPP;
  localparam int          NPAL_M1 = (1 << BPP) - 1;
  localparam int unsigned XW    = $clog2(WIDTH + 1) + 1;
  localparam int unsigned YW    = $clog2(HEIGHT + 1) + 1;
  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [XW-1:0] X_LIM = XW'(WIDTH);
  localparam logic [YW-1:0] Y_LIM = YW'(HEIGHT);

  function automatic logic [23:0] grey_entry(input int idx);
    logic [7:0] lvl;
    lvl = 8'(255 - (idx * 255) / NPAL_M1);
    return {lvl, lvl, lvl};
  endfunction

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] c);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, c};
    return 8'(s >> 1);
  endfunction

  // Palette registers
  logic [23:0] pal [NPAL];

  always_ff @(posedge clk or posedge reset) begin : pal_ff
    if (reset) begin
      for (int i = 0; i < int'(NPAL); i++) pal[i] <= grey_entry(i);
    end else if (pal_wr) begin
      pal[pal_addr] <= pal_din;
    end
  end

  // Position of the pixel on the input this cycle (counter registers hold the
  // value after the previous ce_pix, so clears/increments are folded in here)
  logic [XW-1:0] x_q, x_c;
  logic [YW-1:0] y_q, y_c;
  logic          hb_q, vs_q, armed_q, frame_valid;
  logic          active_c, vs_rise_c, hb_fall_c, in_range_c, wr_c, fv_c;
  logic [AW-1:0] fb_addr_c;

  always_comb begin : pos_c
    active_c  = ~hblank & ~vblank;
    vs_rise_c = vsync & ~vs_q;
    hb_fall_c = hb_q & ~hblank;
    x_c       = hblank ? '0 : x_q;
    y_c       = y_q;
    if (vsync)                         y_c = '0;
    else if (hb_fall_c && y_q != '1)   y_c = y_q + YW'(1);
    in_range_c = (x_c < X_LIM) && (y_c < Y_LIM);
    wr_c       = ce_pix & active_c & in_range_c;
    // The frame started by the first vsync is still filling the RAM, so blend
    // only becomes legal from the second vsync on.
    fv_c       = frame_valid | (vs_rise_c & armed_q);
    fb_addr_c  = AW'(y_c) * AW'(WIDTH) + AW'(x_c);
  end

  always_ff @(posedge clk or posedge reset) begin : pos_ff
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      hb_q        <= 1'b0;
      vs_q        <= 1'b0;
      armed_q     <= 1'b0;
      frame_valid <= 1'b0;
    end else if (ce_pix) begin
      x_q         <= (active_c && x_c != '1) ? x_c + XW'(1) : x_c;
      y_q         <= y_c;
      hb_q        <= hblank;
      vs_q        <= vsync;
      frame_valid <= fv_c;
      if (vs_rise_c) armed_q <= 1'b1;
    end
  end

  // Previous-frame buffer: read-before-write, not reset
  logic [BPP-1:0] fb_mem [DEPTH];
  logic [BPP-1:0] ram_q;

  always_ff @(posedge clk) begin : fb_ram
    if (wr_c) begin
      ram_q             <= fb_mem[fb_addr_c];
      fb_mem[fb_addr_c] <= pixel;
    end
  end

  // Stage 1 registers
  logic [BPP-1:0] cur_q;
  logic           use_ram_q, blank_q;
  logic [3:0]     tim1_q;

  always_ff @(posedge clk or posedge reset) begin : stage1_ff
    if (reset) begin
      cur_q     <= '0;
      use_ram_q <= 1'b0;
      blank_q   <= 1'b0;
      tim1_q    <= '0;
    end else if (ce_pix) begin
      cur_q     <= pixel;
      use_ram_q <= active_c & in_range_c & fv_c;
      blank_q   <= ~active_c;
      tim1_q    <= {hsync, vsync, hblank, vblank};
    end
  end

`ifdef LCD_FX_SHADOW_EN
  localparam int unsigned LXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic logic [7:0] shade8(input logic [7:0] c, input logic [1:0] t);
    logic [11:0] p;
    p = 12'(c) * 12'(4'd15 - {2'b00, t});
    return 8'(p >> 4);
  endfunction

  // Line buffer holds the previous line; the delay register shifts it by one
  // pixel so src is the pixel up-left of the current one.
  logic [BPP-1:0] lb_mem [WIDTH];
  logic [BPP-1:0] lb_rd_c, lb_dly_q, src_c, src_q;

  always_comb begin : shadow_src_c
    lb_rd_c = lb_mem[LXW'(x_c)];
    src_c   = (x_c == '0 || y_c == '0 || !in_range_c) ? '0 : lb_dly_q;
  end

  always_ff @(posedge clk) begin : lb_ram
    if (wr_c) lb_mem[LXW'(x_c)] <= pixel;
  end

  always_ff @(posedge clk or posedge reset) begin : shadow_ff
    if (reset) begin
      lb_dly_q <= '0;
      src_q    <= '0;
    end else if (ce_pix) begin
      if (active_c && in_range_c) lb_dly_q <= lb_rd_c;
      src_q <= src_c;
    end
  end
`else
  logic unused_shadow_en;
  assign unused_shadow_en = shadow_en;
`endif

  // Stage 2: palette lookup, blend, shadow
  logic [23:0]    pal_cur_c, pal_prev_c, mix_c, colour_c;
  logic [BPP-1:0] prev_idx_c;

  always_comb begin : stage2_c
    pal_cur_c  = pal[cur_q];
    prev_idx_c = use_ram_q ? ram_q : cur_q;
    pal_prev_c = pal[prev_idx_c];
    mix_c      = pal_cur_c;
    if (blend_en) begin
      for (int ch = 0; ch < 3; ch++)
        mix_c[ch*8 +: 8] = avg8(pal_cur_c[ch*8 +: 8], pal_prev_c[ch*8 +: 8]);
    end
`ifdef LCD_FX_SHADOW_EN
    if (shadow_en && cur_q == '0 && src_q != '0) begin
      for (int ch = 0; ch < 3; ch++)
        mix_c[ch*8 +: 8] = shade8(mix_c[ch*8 +: 8], src_q[BPP-1 -: 2]);
    end
`endif
    colour_c = blank_q ? '0 : mix_c;
  end

  always_ff @(posedge clk or posedge reset) begin : stage2_ff
    if (reset) begin
      {r, g, b}                              <= '0;
      {hsync_o, vsync_o, hblank_o, vblank_o} <= '0;
    end else if (ce_pix) begin
      {r, g, b}                              <= colour_c;
      {hsync_o, vsync_o, hblank_o, vblank_o} <= tim1_q;
    end
  end

endmodule

// File: tb/tb_lcd_pixel_fx.sv
// Directed testbench for lcd_pixel_fx on an 8x8, 2-bpp frame.
module tb_lcd_pixel_fx;

  localparam int W = 8;
  localparam int H = 8;

`ifdef LCD_FX_SHADOW_EN
  localparam logic [23:0] EXP_DARK3 = 24'hBFBFBF;
  localparam logic [23:0] EXP_DARK1 = 24'hDFDFDF;
`else
  localparam logic [23:0] EXP_DARK3 = 24'hFFFFFF;
  localparam logic [23:0] EXP_DARK1 = 24'hFFFFFF;
`endif

  logic        clk = 1'b0;
  logic        reset, ce_pix;
  logic [1:0]  pixel;
  logic        hsync, vsync, hblank, vblank;
  logic        blend_en, shadow_en, pal_wr;
  logic [1:0]  pal_addr;
  logic [23:0] pal_din;
  logic [7:0]  r, g, b;
  logic        hsync_o, vsync_o, hblank_o, vblank_o;

  int n_pass = 0;
  int n_total = 0;

  logic [1:0]  img [10][10];
  logic [23:0] cap [10][10];
  bit          pend_v = 1'b0;
  int          pend_x = 0;
  int          pend_y = 0;

  lcd_pixel_fx #(.WIDTH(W), .HEIGHT(H), .BPP(2)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .pixel(pixel),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .blend_en(blend_en), .shadow_en(shadow_en),
    .pal_wr(pal_wr), .pal_addr(pal_addr), .pal_din(pal_din),
    .r(r), .g(g), .b(b),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .hblank_o(hblank_o), .vblank_o(vblank_o)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs; records the colour of the pixel sent on
  // the previous step (output lags the input by two edges).
  task automatic step(input logic [1:0] p, input logic hb, input logic vb,
                      input logic hs, input logic vs,
                      input bit tv, input int tx, input int ty);
    pixel = p; hblank = hb; vblank = vb; hsync = hs; vsync = vs;
    @(posedge clk); #1;
    if (pend_v) cap[pend_y][pend_x] = {r, g, b};
    pend_v = tv; pend_x = tx; pend_y = ty;
  endtask

  task automatic fill_img(input logic [1:0] v);
    for (int yy = 0; yy < 10; yy++)
      for (int xx = 0; xx < 10; xx++) img[yy][xx] = v;
  endtask

  task automatic run_frame(input int fw, input int fh);
    step(2'd0, 1, 1, 0, 0, 0, 0, 0);
    step(2'd0, 1, 1, 0, 0, 0, 0, 0);
    for (int yy = 0; yy < fh; yy++) begin
      for (int xx = 0; xx < fw; xx++)
        step(img[yy][xx], 0, 0, 0, (yy == 0 && xx == 0), 1, xx, yy);
      step(2'd0, 1, 0, 1, 0, 0, 0, 0);
      step(2'd0, 1, 0, 0, 0, 0, 0, 0);
    end
    step(2'd0, 1, 1, 0, 0, 0, 0, 0);
    step(2'd0, 1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; ce_pix = 1'b1; pixel = 2'd3;
    hsync = 1'b1; vsync = 1'b1; hblank = 1'b1; vblank = 1'b1;
    blend_en = 1'b0; shadow_en = 1'b0; pal_wr = 1'b0; pal_addr = '0; pal_din = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({r, g, b} !== 24'h0) $display("FAIL reset_rgb: got %h want %h", {r, g, b}, 24'h0);
    else n_pass++;
    n_total++;
    if ({hsync_o, vsync_o, hblank_o, vblank_o} !== 4'b0000)
      $display("FAIL reset_timing: got %b want 0000", {hsync_o, vsync_o, hblank_o, vblank_o});
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_palette_line;
    step(2'd0, 1, 1, 0, 0, 0, 0, 0);
    step(2'd0, 1, 1, 0, 0, 0, 0, 0);
    step(2'd0, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({r, g, b} !== 24'h0) $display("FAIL lat_not_one: got %h want %h", {r, g, b}, 24'h0);
    else n_pass++;
    step(2'd1, 0, 0, 1, 0, 0, 0, 0);
    n_total++;
    if ({r, g, b} !== 24'hFFFFFF) $display("FAIL pal0: got %h want FFFFFF", {r, g, b});
    else n_pass++;
    n_total++;
    if (hsync_o !== 1'b0) $display("FAIL hsync_early: got %b want 0", hsync_o);
    else n_pass++;
    step(2'd2, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({r, g, b} !== 24'hAAAAAA) $display("FAIL pal1: got %h want AAAAAA", {r, g, b});
    else n_pass++;
    n_total++;
    if (hsync_o !== 1'b1) $display("FAIL hsync_delay: got %b want 1", hsync_o);
    else n_pass++;
    step(2'd3, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({r, g, b} !== 24'h555555) $display("FAIL pal2: got %h want 555555", {r, g, b});
    else n_pass++;
    step(2'd0, 1, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({r, g, b} !== 24'h000000) $display("FAIL pal3: got %h want 000000", {r, g, b});
    else n_pass++;
    step(2'd3, 1, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({r, g, b} !== 24'h0 || hblank_o !== 1'b1)
      $display("FAIL blank_out: got rgb %h hblank_o %b want 000000 1", {r, g, b}, hblank_o);
    else n_pass++;
  endtask

  task automatic test_blend;
    blend_en = 1'b1;
    fill_img(2'd0);
    run_frame(W, H);
    pulse_reset();
    fill_img(2'd3);
    run_frame(W, H);
    n_total++;
    if (cap[2][3] !== 24'h0) $display("FAIL blend_first_frame: got %h want 000000", cap[2][3]);
    else n_pass++;
    n_total++;
    if (cap[7][7] !== 24'h0) $display("FAIL blend_first_last: got %h want 000000", cap[7][7]);
    else n_pass++;
    fill_img(2'd0);
    run_frame(W, H);
    n_total++;
    if (cap[0][0] !== 24'h7F7F7F) $display("FAIL blend_origin: got %h want 7F7F7F", cap[0][0]);
    else n_pass++;
    n_total++;
    if (cap[4][5] !== 24'h7F7F7F) $display("FAIL blend_mid: got %h want 7F7F7F", cap[4][5]);
    else n_pass++;
    run_frame(W, H);
    n_total++;
    if (cap[4][5] !== 24'hFFFFFF) $display("FAIL blend_steady: got %h want FFFFFF", cap[4][5]);
    else n_pass++;
    blend_en = 1'b0;
  endtask

  task automatic test_shadow;
    shadow_en = 1'b1;
    fill_img(2'd0);
    img[5][5] = 2'd3;
    img[2][7] = 2'd3;
    img[7][2] = 2'd3;
    run_frame(W, H);
    run_frame(W, H);
    n_total++;
    if (cap[6][6] !== EXP_DARK3) $display("FAIL shadow_t3: got %h want %h", cap[6][6], EXP_DARK3);
    else n_pass++;
    n_total++;
    if (cap[5][5] !== 24'h0) $display("FAIL shadow_src_px: got %h want 000000", cap[5][5]);
    else n_pass++;
    n_total++;
    if (cap[6][5] !== 24'hFFFFFF) $display("FAIL shadow_below: got %h want FFFFFF", cap[6][5]);
    else n_pass++;
    n_total++;
    if (cap[4][0] !== 24'hFFFFFF) $display("FAIL shadow_col0: got %h want FFFFFF", cap[4][0]);
    else n_pass++;
    n_total++;
    if (cap[0][3] !== 24'hFFFFFF) $display("FAIL shadow_row0: got %h want FFFFFF", cap[0][3]);
    else n_pass++;
    img[5][5] = 2'd1;
    run_frame(W, H);
    n_total++;
    if (cap[6][6] !== EXP_DARK1) $display("FAIL shadow_t1: got %h want %h", cap[6][6], EXP_DARK1);
    else n_pass++;
    shadow_en = 1'b0;
  endtask

  task automatic test_pal_write_and_hold;
    step(2'd0, 1, 1, 0, 0, 0, 0, 0);
    step(2'd2, 0, 0, 0, 0, 0, 0, 0);
    pal_wr = 1'b1; pal_addr = 2'd2; pal_din = 24'h112233;
    step(2'd2, 0, 0, 0, 0, 0, 0, 0);
    pal_wr = 1'b0;
    n_total++;
    if ({r, g, b} !== 24'h555555) $display("FAIL palwr_old: got %h want 555555", {r, g, b});
    else n_pass++;
    step(2'd2, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({r, g, b} !== 24'h112233) $display("FAIL palwr_new: got %h want 112233", {r, g, b});
    else n_pass++;
    ce_pix = 1'b0; pixel = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({r, g, b} !== 24'h112233) $display("FAIL ce_hold_out: got %h want 112233", {r, g, b});
    else n_pass++;
    ce_pix = 1'b1;
    step(2'd3, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({r, g, b} !== 24'h112233) $display("FAIL ce_hold_stage1: got %h want 112233", {r, g, b});
    else n_pass++;
    step(2'd0, 1, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({r, g, b} !== 24'h000000) $display("FAIL ce_resume: got %h want 000000", {r, g, b});
    else n_pass++;
  endtask

  task automatic test_reset_midline;
    blend_en = 1'b1;
    step(2'd0, 1, 1, 0, 0, 0, 0, 0);
    step(2'd0, 0, 0, 0, 0, 0, 0, 0);
    step(2'd0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({r, g, b} !== 24'h0) $display("FAIL reset_async: got %h want 000000", {r, g, b});
    else n_pass++;
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    step(2'd0, 1, 1, 0, 0, 0, 0, 0);
    step(2'd2, 0, 0, 0, 0, 0, 0, 0);
    step(2'd2, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({r, g, b} !== 24'h555555) $display("FAIL pal_restored: got %h want 555555", {r, g, b});
    else n_pass++;
    fill_img(2'd3);
    run_frame(W, H);
    n_total++;
    if (cap[3][3] !== 24'h0) $display("FAIL rst_frame1: got %h want 000000", cap[3][3]);
    else n_pass++;
    fill_img(2'd0);
    run_frame(W, H);
    n_total++;
    if (cap[3][3] !== 24'h7F7F7F) $display("FAIL rst_frame2: got %h want 7F7F7F", cap[3][3]);
    else n_pass++;
    fill_img(2'd0);
    img[0][8] = 2'd3;
    img[0][9] = 2'd3;
    img[8][0] = 2'd3;
    run_frame(10, 10);
    n_total++;
    if (cap[1][0] !== 24'hFFFFFF) $display("FAIL oversize_nocorrupt: got %h want FFFFFF", cap[1][0]);
    else n_pass++;
    n_total++;
    if (cap[0][8] !== 24'h0) $display("FAIL oversize_x: got %h want 000000", cap[0][8]);
    else n_pass++;
    n_total++;
    if (cap[8][0] !== 24'h0) $display("FAIL oversize_y: got %h want 000000", cap[8][0]);
    else n_pass++;
    blend_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_palette_line();
    test_blend();
    test_shadow();
    test_pal_write_and_hold();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
